// File: rtl/instr_mem_ctrl_pkg.sv
// Shared constants and state encoding for the instruction memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_DATA_W = 18;
  localparam int IMEM_DEPTH  = 1024;

  // Controller sequencing: hold CPU, stream program in, one-cycle done, run.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    RUN  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Bundles the loader, fetch and memory-port signals of the instruction memory controller.
// Latency: n/a (wiring only).
// Backpressure: load path uses load_valid/load_ready; fetch path has no backpressure.
interface instr_mem_ctrl_if
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
);

  // Loader side
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
  logic [DATA_W-1:0] load_sum;

  // CPU fetch side
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              cpu_hold;

  // Memory array side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Controller view: serves the loader and CPU, owns the memory port.
  modport slave (
    input  load_start, load_len, load_valid, load_data,
    input  fetch_req, fetch_addr,
    input  mem_rdata,
    output load_ready, load_done, load_sum,
    output fetch_valid, fetch_data, cpu_hold,
    output mem_addr, mem_we, mem_wdata
  );

  // Environment view: loader, CPU fetch stage and memory array.
  modport master (
    output load_start, load_len, load_valid, load_data,
    output fetch_req, fetch_addr,
    output mem_rdata,
    input  load_ready, load_done, load_sum,
    input  fetch_valid, fetch_data, cpu_hold,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/instr_mem_ctrl_load_seq.sv
// Program-load sequencer: length clamp, write pointer, word counter and checksum.
// Latency: write signals are combinational with the accept; last_word flags the len-th accept.
// Backpressure: none internally; the caller only asserts accept_i when a word is taken.
module imem_load_seq #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              last_word_o,
  output logic              len_zero_o,
  output logic [DATA_W-1:0] sum_o
);

  // Longest legal load; longer requests are cut so the pointer never wraps.
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [ADDR_W:0]   len_clamped;

  // Clamp the requested length to the memory depth.
  always_comb begin
    len_clamped = (len_i > LEN_MAX) ? LEN_MAX : len_i;
  end

  // Start re-arms the sequencer; each accepted word advances pointer, count and sum.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    len_d = len_q;
    sum_d = sum_q;
    if (start_i) begin
      len_d = len_clamped;
      ptr_d = '0;
      cnt_d = '0;
      sum_d = '0;
    end else if (accept_i) begin
      ptr_d = ptr_q + ADDR_W'(1);
      cnt_d = cnt_q + (ADDR_W+1)'(1);
      sum_d = sum_q + data_i;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      sum_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      sum_q <= sum_d;
    end
  end

  assign wr_en_o     = accept_i;
  assign wr_addr_o   = ptr_q;
  assign wr_data_o   = data_i;
  assign last_word_o = accept_i && ((cnt_q + (ADDR_W+1)'(1)) == len_q);
  assign len_zero_o  = (len_q == '0);
  assign sum_o       = sum_q;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: arbitrates the single memory port between loader and CPU fetch.
// Latency: writes land the cycle a word is accepted; fetch data returns one cycle after the request.
// Backpressure: load_ready only in LOAD; the CPU is stalled via cpu_hold outside RUN.
module instr_mem_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH   // must equal 2**ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  instr_mem_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_DONE = DONE;
  localparam logic [1:0] S_RUN  = RUN;

  logic [1:0]        state_q, state_d;
  logic              in_run;
  logic              start_go;
  logic              load_ready;
  logic              accept;
  logic              fetch_go;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              last_word;
  logic              len_zero;
  logic [DATA_W-1:0] load_sum;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we;

  logic              fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;

  assign in_run = (state_q == S_RUN);

  // Reset wins over every input in the same cycle, so all request paths are gated by it.
  // A zero-length load never opens the write path.
  always_comb begin
    start_go   = bus.load_start && !reset &&
                 ((state_q == S_IDLE) || (state_q == S_RUN));
    load_ready = (state_q == S_LOAD) && !len_zero && !reset;
    accept     = bus.load_valid && load_ready;
    fetch_go   = in_run && bus.fetch_req && !reset;
  end

  imem_load_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_load_seq (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_go),
    .len_i       (bus.load_len),
    .accept_i    (accept),
    .data_i      (bus.load_data),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .last_word_o (last_word),
    .len_zero_o  (len_zero),
    .sum_o       (load_sum)
  );

  // Controller FSM: IDLE -> LOAD -> DONE -> RUN, with reload from RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_go) state_d = S_LOAD;
      S_LOAD: if (len_zero || last_word) state_d = S_DONE;
      S_DONE: state_d = S_RUN;
      S_RUN:  if (start_go) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Port mux: writes only happen in LOAD and reads only in RUN, so the two never collide;
  // an idle port keeps the last address and write data.
  always_comb begin
    mem_we      = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (wr_en) begin
      mem_we      = 1'b1;
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
    end else if (fetch_go) begin
      mem_addr_d  = bus.fetch_addr;
    end
  end

  // Remember the last driven address/data so an idle port holds steady.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Fetch return: the array's registered read data is presented the cycle after the request;
  // between returns the last word is held for the CPU.
  always_comb begin
    fetch_valid_d = fetch_go;
    fetch_data_d  = fetch_valid_q ? bus.mem_rdata : fetch_data_q;
  end

  // Fetch-return registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.load_done   = (state_q == S_DONE);
  assign bus.load_sum    = load_sum;
  assign bus.cpu_hold    = !in_run;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_data  = fetch_data_d;
  assign bus.mem_addr    = mem_addr_d;
  assign bus.mem_we      = mem_we;
  assign bus.mem_wdata   = mem_wdata_d;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Self-checking bench for instr_mem_ctrl with a synchronous-read memory model.
// Latency: expected writes/fetch returns queued at drive time, popped by the port monitor.
// Backpressure: loader stimulus only counts a word when the controller should be ready.
module tb_instr_mem_ctrl;
  import imem_pkg::*;

  typedef struct {
    logic [9:0]  addr;
    logic [17:0] data;
  } wr_exp_t;

  typedef struct {
    logic [17:0] data;
    int          cyc;
  } rd_exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_mem_ctrl_if bus ();

  instr_mem_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [17:0] tb_mem  [0:1023];
  logic [17:0] ref_mem [0:1023];
  logic [17:0] wbuf    [0:1023];
  wr_exp_t     wq[$];
  rd_exp_t     fq[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory array: write-enable port, registered read.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= tb_mem[bus.mem_addr];
  end

  // Scoreboard monitor on the memory write port and fetch return.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h", bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_exp_t w;
        w = wq.pop_front();
        if (bus.mem_addr !== w.addr || bus.mem_wdata !== w.data) begin
          bad++;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   bus.mem_addr, bus.mem_wdata, w.addr, w.data);
        end
      end
    end
    if (bus.fetch_valid === 1'b1) begin
      total++;
      if (fq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_fetch data=%h cyc=%0d", bus.fetch_data, cyc);
      end else begin
        rd_exp_t r;
        r = fq.pop_front();
        if (bus.fetch_data !== r.data || cyc != r.cyc) begin
          bad++;
          $display("FAIL fetch got data=%h cyc=%0d want data=%h cyc=%0d",
                   bus.fetch_data, cyc, r.data, r.cyc);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.load_start = 1'b1; bus.load_len = 11'd4; bus.load_valid = 1'b1;
    bus.load_data = 18'h1; bus.fetch_req = 1'b1; bus.fetch_addr = 10'd0;
    repeat (2) next_cycle();
    @(negedge clk);
    total++; if (bus.load_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_in_reset got=%b want=0", bus.load_ready); end
    total++; if (bus.cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_hold_in_reset got=%b want=1", bus.cpu_hold); end
    next_cycle();
    reset = 1'b0;
    bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.fetch_req = 1'b0;
    @(negedge clk);
    total++; if ({bus.load_ready, bus.load_done, bus.fetch_valid, bus.mem_we} !== 4'b0000) begin
      bad++; $display("FAIL rst_flags got=%b want=0000", {bus.load_ready, bus.load_done, bus.fetch_valid, bus.mem_we});
    end
    total++; if (bus.cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_hold got=%b want=1", bus.cpu_hold); end
    total++; if (bus.mem_addr !== 10'd0 || bus.mem_wdata !== 18'd0) begin
      bad++; $display("FAIL rst_mem_port got addr=%h wdata=%h want 0", bus.mem_addr, bus.mem_wdata);
    end
    total++; if (bus.fetch_data !== 18'd0 || bus.load_sum !== 18'd0) begin
      bad++; $display("FAIL rst_data got fetch=%h sum=%h want 0", bus.fetch_data, bus.load_sum);
    end
    next_cycle();
  endtask

  task automatic test_fetch_without_load();
    bus.fetch_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.fetch_addr = 10'(i * 3);
      @(negedge clk);
      total++; if (bus.cpu_hold !== 1'b1 || bus.fetch_valid !== 1'b0 || bus.mem_we !== 1'b0) begin
        bad++; $display("FAIL idle_fetch got hold=%b valid=%b we=%b want 1 0 0",
                        bus.cpu_hold, bus.fetch_valid, bus.mem_we);
      end
      next_cycle();
    end
    bus.fetch_req = 1'b0;
  endtask

  // Runs one load; wbuf holds the words, gap inserts one idle cycle after the first word,
  // fetch_same issues a fetch of faddr in the load_start cycle and keeps fetch_req high.
  task automatic run_load(input logic [10:0] len, input int nacc, input bit gap,
                          input bit start_hold, input bit fetch_same, input logic [9:0] faddr);
    logic [17:0] sum;
    int sent;
    int step;
    bit v;
    sum = '0; sent = 0; step = 0;
    bus.load_start = 1'b1; bus.load_len = len; bus.load_valid = 1'b0;
    bus.fetch_req = fetch_same; bus.fetch_addr = faddr;
    if (fetch_same) fq.push_back('{data: ref_mem[faddr], cyc: cyc + 1});
    @(negedge clk);
    total++; if (bus.load_ready !== 1'b0 || bus.cpu_hold !== start_hold) begin
      bad++; $display("FAIL start_cycle got ready=%b hold=%b want 0 %b", bus.load_ready, bus.cpu_hold, start_hold);
    end
    next_cycle();
    bus.load_start = 1'b0;
    while (sent < nacc) begin
      v = !(gap && step == 1);
      bus.load_valid = v;
      bus.load_data = wbuf[sent];
      if (v) begin
        wq.push_back('{addr: 10'(sent), data: wbuf[sent]});
        ref_mem[sent] = wbuf[sent];
        sum = sum + wbuf[sent];
        sent++;
      end
      @(negedge clk);
      total++; if (bus.load_ready !== 1'b1 || bus.load_done !== 1'b0 || bus.cpu_hold !== 1'b1) begin
        bad++; $display("FAIL in_load step=%0d got ready=%b done=%b hold=%b want 1 0 1",
                        step, bus.load_ready, bus.load_done, bus.cpu_hold);
      end
      if (v && sent == nacc) begin
        total++; if (bus.mem_addr !== 10'(nacc - 1)) begin
          bad++; $display("FAIL last_write_addr got=%0d want=%0d", bus.mem_addr, nacc - 1);
        end
      end
      next_cycle();
      step++;
    end
    bus.load_valid = 1'b1; bus.load_data = 18'h2AAAA; bus.fetch_req = 1'b0;
    if (len == 11'd0) begin
      @(negedge clk);
      total++; if (bus.load_ready !== 1'b0 || bus.load_done !== 1'b0) begin
        bad++; $display("FAIL zero_len_load got ready=%b done=%b want 0 0", bus.load_ready, bus.load_done);
      end
      next_cycle();
    end
    @(negedge clk);
    total++; if (bus.load_done !== 1'b1 || bus.load_ready !== 1'b0 || bus.cpu_hold !== 1'b1) begin
      bad++; $display("FAIL done_cycle got done=%b ready=%b hold=%b want 1 0 1",
                      bus.load_done, bus.load_ready, bus.cpu_hold);
    end
    total++; if (bus.load_sum !== sum) begin
      bad++; $display("FAIL load_sum got=%h want=%h", bus.load_sum, sum);
    end
    next_cycle();
    bus.load_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.load_done !== 1'b0 || bus.cpu_hold !== 1'b0) begin
      bad++; $display("FAIL run_entry got done=%b hold=%b want 0 0", bus.load_done, bus.cpu_hold);
    end
    next_cycle();
  endtask

  task automatic test_load_basic();
    wbuf[0] = 18'h00001; wbuf[1] = 18'h00002; wbuf[2] = 18'h3FFFF; wbuf[3] = 18'h00010;
    run_load(11'd4, 4, 1'b1, 1'b1, 1'b0, 10'd0);
  endtask

  task automatic test_back_to_back(input logic [9:0] a0, input logic [9:0] a1,
                                   input logic [9:0] a2, input logic [9:0] a3);
    logic [9:0] a [4];
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    for (int i = 0; i < 4; i++) begin
      bus.fetch_req = 1'b1;
      bus.fetch_addr = a[i];
      fq.push_back('{data: ref_mem[a[i]], cyc: cyc + 1});
      @(negedge clk);
      total++; if (bus.mem_addr !== a[i] || bus.mem_we !== 1'b0 || bus.cpu_hold !== 1'b0) begin
        bad++; $display("FAIL fetch_port got addr=%h we=%b hold=%b want addr=%h 0 0",
                        bus.mem_addr, bus.mem_we, bus.cpu_hold, a[i]);
      end
      next_cycle();
    end
    bus.fetch_req = 1'b0;
    repeat (2) next_cycle();
    total++; if (fq.size() != 0) begin
      bad++; $display("FAIL fetch_drain got pending=%0d want 0", fq.size());
    end
  endtask

  task automatic test_reload_during_run();
    wbuf[0] = 18'h0AAAA; wbuf[1] = 18'h15555;
    run_load(11'd2, 2, 1'b0, 1'b0, 1'b1, 10'd2);
    test_back_to_back(10'd0, 10'd1, 10'd2, 10'd3);
  endtask

  task automatic test_len_zero();
    run_load(11'd0, 0, 1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  task automatic test_len_clamp();
    for (int i = 0; i < 1024; i++) wbuf[i] = 18'((i * 257 + 3) ^ (i << 7));
    run_load(11'd2047, 1024, 1'b0, 1'b0, 1'b0, 10'd0);
    test_back_to_back(10'd1023, 10'd0, 10'd512, 10'd1);
  endtask

  task automatic test_reset_mid_load();
    wbuf[0] = 18'h00111; wbuf[1] = 18'h00222;
    bus.load_start = 1'b1; bus.load_len = 11'd4;
    next_cycle();
    bus.load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.load_valid = 1'b1; bus.load_data = wbuf[i];
      wq.push_back('{addr: 10'(i), data: wbuf[i]});
      ref_mem[i] = wbuf[i];
      next_cycle();
    end
    reset = 1'b1; bus.load_data = 18'h33333;
    @(negedge clk);
    total++; if (bus.load_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
      bad++; $display("FAIL mid_reset_cycle got ready=%b we=%b want 0 0", bus.load_ready, bus.mem_we);
    end
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (bus.load_ready !== 1'b0 || bus.load_done !== 1'b0 || bus.cpu_hold !== 1'b1 ||
                   bus.mem_we !== 1'b0 || bus.load_sum !== 18'd0) begin
        bad++; $display("FAIL after_mid_reset got ready=%b done=%b hold=%b we=%b sum=%h want 0 0 1 0 0",
                        bus.load_ready, bus.load_done, bus.cpu_hold, bus.mem_we, bus.load_sum);
      end
      next_cycle();
    end
    bus.load_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch_without_load();
    test_load_basic();
    test_back_to_back(10'd0, 10'd1, 10'd2, 10'd3);
    test_reload_during_run();
    test_len_zero();
    test_len_clamp();
    test_reset_mid_load();
    total++; if (wq.size() != 0) begin
      bad++; $display("FAIL write_drain got pending=%0d want 0", wq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
